i2s_rx: RTL

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// ============================================================================
// Module   : i2s_rx
// Brief    : I2S receiver that captures one 24-bit sample per channel slot.
//            Define I2S_RX_SYNC_EN to insert 2-flop input synchronizers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_rx #(
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        bclk,
    input  logic        lrck,
    input  logic        sdin,
    output logic [23:0] out_data,
    output logic        out_valid,
    output logic        out_right,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [6:0] SLOT_MAX = 7'(SLOT_BITS);

    logic bclk_s, lrck_s, sdin_s, bclk_prev;

`ifdef I2S_RX_SYNC_EN
    logic [2:0] sync_m1, sync_m2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_m1                  <= 3'b000;
            sync_m2                  <= 3'b000;
            {bclk_s, lrck_s, sdin_s} <= 3'b000;
        end else begin
            sync_m1                  <= {bclk, lrck, sdin};
            sync_m2                  <= sync_m1;
            {bclk_s, lrck_s, sdin_s} <= sync_m2;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            {bclk_s, lrck_s, sdin_s} <= 3'b000;
        end else begin
            {bclk_s, lrck_s, sdin_s} <= {bclk, lrck, sdin};
        end
    end
`endif

    logic       rise, lrck_edge, slot_over;
    logic       lrck_last, primed;
    logic [6:0] slot_cnt;

    assign rise = bclk_s & ~bclk_prev;
    // The first rise after reset only primes lrck_last, so a word already in
    // flight at reset release cannot masquerade as a fresh slot start.
    assign lrck_edge = rise & primed & (lrck_s ^ lrck_last);
    assign slot_over = (slot_cnt >= SLOT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_prev <= 1'b0;
            lrck_last <= 1'b0;
            primed    <= 1'b0;
            slot_cnt  <= 7'd0;
        end else begin
            bclk_prev <= bclk_s;
            if (rise) begin
                lrck_last <= lrck_s;
                primed    <= 1'b1;
                if (lrck_edge) begin
                    slot_cnt <= 7'd0;
                end else if (slot_cnt != 7'h7F) begin
                    slot_cnt <= slot_cnt + 7'd1;
                end
            end
        end
    end

    state_t      state, state_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [23:0] shreg, shreg_n, data_n;
    logic        chan, chan_n, right_n, valid_n, err_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 5'd0;
            shreg     <= 24'd0;
            chan      <= 1'b0;
            out_data  <= 24'd0;
            out_right <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            chan      <= chan_n;
            out_data  <= data_n;
            out_right <= right_n;
            out_valid <= valid_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        chan_n    = chan;
        data_n    = out_data;
        right_n   = out_right;
        valid_n   = 1'b0;
        err_n     = 1'b0;

        if (!enable) begin
            state_n = IDLE;
        end else if (rise) begin
            if (lrck_edge) begin
                // Bit under the edge belongs to the previous word (one-bit delay).
                err_n     = (state == SHIFT);
                state_n   = SHIFT;
                bit_cnt_n = 5'd0;
                chan_n    = lrck_s;
            end else if (state != IDLE && slot_over) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else if (state == SHIFT) begin
                shreg_n   = {shreg[22:0], sdin_s};
                bit_cnt_n = bit_cnt + 5'd1;
                if (bit_cnt == 5'd23) begin
                    data_n  = {shreg[22:0], sdin_s};
                    right_n = chan;
                    valid_n = 1'b1;
                    state_n = WAIT;
                end
            end
        end
    end

endmodule

`default_nettype wire
